// File: rtl/pipe_advance_ctrl.sv
// Stall/flush sequencer for the 5-stage LC-3b pipeline.
// Holds every stage while instruction or data memory is still busy. Inserts a
// bubble on a load-use hazard. Flushes the younger stages when MEM resolves a
// taken branch. Also keeps a saturating stall counter and a sticky wait watchdog.
module pipe_advance_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_req,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             load_use,
  input  logic             branch_taken,
  output logic             imem_read,
  output logic             dmem_go,
  output logic             advance_pc,
  output logic             advance_ifid,
  output logic             advance_idex,
  output logic             advance_exmem,
  output logic             advance_memwb,
  output logic             bubble_idex,
  output logic             flush,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IDONE = 2'd1,
    DDONE = 2'd2
  } state_t;

  localparam logic [31:0]      TIMEOUT_V = 32'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t      state, state_next;
  logic        i_done, d_done;
  logic        i_ok, d_ok, go, adv_en;
  logic [31:0] wait_cnt;

  // Completion-tracking state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Next state: remember which memory finished first while the other is still busy
  always_comb begin
    state_next = state;
    if (go) begin
      state_next = RUN;
    end else begin
      case (state)
        RUN: begin
          if (imem_resp)      state_next = IDONE;
          else if (dmem_resp) state_next = DDONE;
        end
        default: state_next = state;
      endcase
    end
  end

  // Go condition and gated strobes. Everything is held low while reset is high.
  always_comb begin
    i_done        = (state == IDONE);
    d_done        = (state == DDONE);
    i_ok          = !imem_req || i_done || imem_resp;
    d_ok          = !dmem_req || d_done || dmem_resp;
    go            = i_ok && d_ok;
    adv_en        = go && !reset;
    imem_read     = !reset && imem_req && !i_done;
    dmem_go       = !reset && dmem_req && !d_done;
    advance_pc    = 1'b0;
    advance_ifid  = 1'b0;
    advance_idex  = 1'b0;
    advance_exmem = 1'b0;
    advance_memwb = 1'b0;
    bubble_idex   = 1'b0;
    flush         = 1'b0;
    if (adv_en) begin
      advance_idex  = 1'b1;
      advance_exmem = 1'b1;
      advance_memwb = 1'b1;
      if (branch_taken) begin
        advance_pc   = 1'b1;
        advance_ifid = 1'b1;
        flush        = 1'b1;
      end else if (load_use) begin
        bubble_idex  = 1'b1;
      end else begin
        advance_pc   = 1'b1;
        advance_ifid = 1'b1;
      end
    end
  end

  // Stall statistics and watchdog. The watchdog fires on the wait cycle that
  // brings wait_cnt up to TIMEOUT, so the flag becomes visible at the same time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (go) begin
      wait_cnt <= '0;
    end else begin
      if (wait_cnt != '1)
        wait_cnt <= wait_cnt + 32'd1;
      if (stall_count != CNT_MAX)
        stall_count <= stall_count + CNT_W'(1);
      if ((TIMEOUT != 0) && (wait_cnt + 32'd1 == TIMEOUT_V))
        mem_timeout <= 1'b1;
    end
  end

endmodule
